// File: rtl/nv_nvdla_cmac_op_sched_if.sv
// CMAC scheduler bus: register-file group config in, shadow config and
// atomic handshake toward the MAC datapath, done/clear back to the register file.
interface nv_nvdla_cmac_op_sched_if #(
    parameter int unsigned ATOMIC_W = 21,
    parameter int unsigned SLCG_W   = 9
);
    logic                reg2dp_d0_op_en;
    logic                reg2dp_d1_op_en;
    logic [1:0]          reg2dp_d0_proc_precision;
    logic [1:0]          reg2dp_d1_proc_precision;
    logic                reg2dp_d0_conv_mode;
    logic                reg2dp_d1_conv_mode;
    logic [ATOMIC_W-1:0] reg2dp_d0_atomics;
    logic [ATOMIC_W-1:0] reg2dp_d1_atomics;
    logic                dp_in_pvld;
    logic                dp_in_prdy;
    logic                cfg_reg_en;
    logic                cfg_is_int8;
    logic                cfg_is_int16;
    logic                cfg_is_fp16;
    logic                cfg_is_wg;
    logic                cfg_prec_err;
    logic [SLCG_W-1:0]   slcg_op_en;
    logic                dp2reg_consumer;
    logic                dp2reg_done;
    logic                dp2reg_d0_op_en_clr;
    logic                dp2reg_d1_op_en_clr;

    // Register file plus datapath side.
    modport master (
        output reg2dp_d0_op_en, reg2dp_d1_op_en,
        output reg2dp_d0_proc_precision, reg2dp_d1_proc_precision,
        output reg2dp_d0_conv_mode, reg2dp_d1_conv_mode,
        output reg2dp_d0_atomics, reg2dp_d1_atomics,
        output dp_in_pvld,
        input  dp_in_prdy, cfg_reg_en,
        input  cfg_is_int8, cfg_is_int16, cfg_is_fp16, cfg_is_wg, cfg_prec_err,
        input  slcg_op_en, dp2reg_consumer, dp2reg_done,
        input  dp2reg_d0_op_en_clr, dp2reg_d1_op_en_clr
    );

    // Scheduler side.
    modport slave (
        input  reg2dp_d0_op_en, reg2dp_d1_op_en,
        input  reg2dp_d0_proc_precision, reg2dp_d1_proc_precision,
        input  reg2dp_d0_conv_mode, reg2dp_d1_conv_mode,
        input  reg2dp_d0_atomics, reg2dp_d1_atomics,
        input  dp_in_pvld,
        output dp_in_prdy, cfg_reg_en,
        output cfg_is_int8, cfg_is_int16, cfg_is_fp16, cfg_is_wg, cfg_prec_err,
        output slcg_op_en, dp2reg_consumer, dp2reg_done,
        output dp2reg_d0_op_en_clr, dp2reg_d1_op_en_clr
    );
endinterface

// File: rtl/nv_nvdla_cmac_op_sched.sv
// CMAC operation scheduler: ping-pong group selection, shadow config latch,
// atomic acceptance count and pipeline drain ahead of the layer-done pulse.
module nv_nvdla_cmac_op_sched #(
    parameter int unsigned ATOMIC_W  = 21,
    parameter int unsigned DRAIN_CYC = 8,
    parameter int unsigned SLCG_W    = 9
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    nv_nvdla_cmac_op_sched_if.slave      sched
);

    localparam int unsigned DRAIN_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    logic                consumer;
    logic [ATOMIC_W-1:0] atomic_cnt;
    logic [ATOMIC_W-1:0] shadow_atomics;
    logic [DRAIN_W-1:0]  drain_cnt;

    logic                prdy_q;
    logic                reg_en_q;
    logic                done_q;
    logic                d0_clr_q;
    logic                d1_clr_q;
    logic                is_int8_q;
    logic                is_int16_q;
    logic                is_fp16_q;
    logic                is_wg_q;
    logic                prec_err_q;
    logic                busy_q;

    logic                sel_op_en;
    logic [1:0]          sel_prec;
    logic                sel_wg;
    logic [ATOMIC_W-1:0] sel_atomics;
    logic                accept;

    // Group currently owned by the consumer pointer; the other group is ignored.
    always_comb begin
        sel_op_en   = sched.reg2dp_d0_op_en;
        sel_prec    = sched.reg2dp_d0_proc_precision;
        sel_wg      = sched.reg2dp_d0_conv_mode;
        sel_atomics = sched.reg2dp_d0_atomics;
        if (consumer) begin
            sel_op_en   = sched.reg2dp_d1_op_en;
            sel_prec    = sched.reg2dp_d1_proc_precision;
            sel_wg      = sched.reg2dp_d1_conv_mode;
            sel_atomics = sched.reg2dp_d1_atomics;
        end
    end

    assign accept = sched.dp_in_pvld & prdy_q;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state          <= IDLE;
            consumer       <= 1'b0;
            atomic_cnt     <= '0;
            shadow_atomics <= '0;
            drain_cnt      <= '0;
            prdy_q         <= 1'b0;
            reg_en_q       <= 1'b0;
            done_q         <= 1'b0;
            d0_clr_q       <= 1'b0;
            d1_clr_q       <= 1'b0;
            is_int8_q      <= 1'b0;
            is_int16_q     <= 1'b1;
            is_fp16_q      <= 1'b0;
            is_wg_q        <= 1'b0;
            prec_err_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            reg_en_q <= 1'b0;
            done_q   <= 1'b0;
            d0_clr_q <= 1'b0;
            d1_clr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_op_en) begin
                        state    <= LOAD;
                        reg_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                LOAD: begin
                    shadow_atomics <= sel_atomics;
                    is_int8_q      <= (sel_prec == 2'd0);
                    is_int16_q     <= (sel_prec == 2'd1);
                    is_fp16_q      <= (sel_prec == 2'd2);
                    prec_err_q     <= (sel_prec == 2'd3);
                    is_wg_q        <= sel_wg;
                    atomic_cnt     <= '0;
                    prdy_q         <= 1'b1;
                    state          <= RUN;
                end
                RUN: begin
                    // The final beat leaves the counter at shadow_atomics; it never wraps.
                    if (accept) begin
                        if (atomic_cnt == shadow_atomics) begin
                            prdy_q    <= 1'b0;
                            drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
                            state     <= DRAIN;
                        end else begin
                            atomic_cnt <= atomic_cnt + ATOMIC_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        done_q   <= 1'b1;
                        d0_clr_q <= ~consumer;
                        d1_clr_q <= consumer;
                        state    <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    consumer <= ~consumer;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    prdy_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign sched.dp_in_prdy          = prdy_q;
    assign sched.cfg_reg_en          = reg_en_q;
    assign sched.cfg_is_int8         = is_int8_q;
    assign sched.cfg_is_int16        = is_int16_q;
    assign sched.cfg_is_fp16         = is_fp16_q;
    assign sched.cfg_is_wg           = is_wg_q;
    assign sched.cfg_prec_err        = prec_err_q;
    assign sched.slcg_op_en          = {SLCG_W{busy_q}};
    assign sched.dp2reg_consumer     = consumer;
    assign sched.dp2reg_done         = done_q;
    assign sched.dp2reg_d0_op_en_clr = d0_clr_q;
    assign sched.dp2reg_d1_op_en_clr = d1_clr_q;

endmodule

// File: tb/tb_nv_nvdla_cmac_op_sched.sv
// Bench for the CMAC operation scheduler: directed layer scenarios plus a
// randomized run, all checked each cycle against a timestamp-based layer model.
module tb_nv_nvdla_cmac_op_sched;

    localparam int ATOMIC_W = 21;
    localparam int DRAIN    = 8;
    localparam int SLCG_W   = 9;
    localparam int SLCG_ALL = (1 << SLCG_W) - 1;

    bit nvdla_core_clk = 1'b0;
    bit nvdla_core_rst = 1'b1;

    nv_nvdla_cmac_op_sched_if #(.ATOMIC_W(ATOMIC_W), .SLCG_W(SLCG_W)) bus ();

    nv_nvdla_cmac_op_sched #(.ATOMIC_W(ATOMIC_W), .DRAIN_CYC(DRAIN), .SLCG_W(SLCG_W)) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .sched          (bus.slave)
    );

    initial forever #5 nvdla_core_clk = ~nvdla_core_clk;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    // Layer model: a layer is described by when it was selected (m_tsel),
    // how many beats remain, and when its last beat landed (m_r).
    bit m_valid = 1'b0;
    bit m_busy  = 1'b0;
    bit m_cons  = 1'b0;
    int m_tsel  = -100;
    int m_left  = 0;
    int m_r     = -1;
    bit m_i8 = 1'b0, m_i16 = 1'b1, m_fp = 1'b0, m_wg = 1'b0, m_err = 1'b0;

    // Observations recorded by the checking process.
    bit prdy_seen  = 1'b0;
    bit regen_seen = 1'b0;
    int bl_cnt = 0, bl_first = -1, bl_last = -1;
    int ev_load = -1, ev_done = -1, ev_clr0 = -1, ev_clr1 = -1, ev_cons = -1;
    bit prev_cons = 1'b0;

    always @(posedge nvdla_core_clk) begin
        int c;
        int prec;
        c = cyc;
        if (!nvdla_core_rst && prdy_seen && bus.dp_in_pvld) begin
            if (bl_cnt == 0) bl_first = c;
            bl_cnt  = bl_cnt + 1;
            bl_last = c;
        end
        if (regen_seen || nvdla_core_rst) bl_cnt = 0;

        if (nvdla_core_rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_cons = 1'b0;
            m_tsel = -100; m_left = 0; m_r = -1;
            m_i8 = 1'b0; m_i16 = 1'b1; m_fp = 1'b0; m_wg = 1'b0; m_err = 1'b0;
        end else if (!m_busy) begin
            if (m_cons ? bus.reg2dp_d1_op_en : bus.reg2dp_d0_op_en) begin
                m_busy = 1'b1; m_tsel = c; m_left = 0; m_r = -1;
            end
        end else if (c == m_tsel + 1) begin
            prec   = m_cons ? int'(bus.reg2dp_d1_proc_precision) : int'(bus.reg2dp_d0_proc_precision);
            m_wg   = m_cons ? bus.reg2dp_d1_conv_mode : bus.reg2dp_d0_conv_mode;
            m_left = 1 + (m_cons ? int'(bus.reg2dp_d1_atomics) : int'(bus.reg2dp_d0_atomics));
            m_i8   = (prec == 0);
            m_i16  = (prec == 1);
            m_fp   = (prec == 2);
            m_err  = (prec == 3);
        end else if (m_left > 0) begin
            if (bus.dp_in_pvld) begin
                m_left = m_left - 1;
                if (m_left == 0) m_r = c;
            end
        end else if (c == m_r + DRAIN + 1) begin
            m_busy = 1'b0;
            m_cons = ~m_cons;
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errs = errs + 1;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        bit e_prdy, e_done;
        if (m_valid) begin
            e_prdy = m_busy && (cyc >= m_tsel + 2) && (m_left > 0);
            e_done = m_busy && (m_r >= 0) && (m_left == 0) && (cyc == m_r + DRAIN + 1);
            chk("prdy",     int'(bus.dp_in_prdy),          int'(e_prdy));
            chk("reg_en",   int'(bus.cfg_reg_en),          int'(m_busy && cyc == m_tsel + 1));
            chk("done",     int'(bus.dp2reg_done),         int'(e_done));
            chk("d0_clr",   int'(bus.dp2reg_d0_op_en_clr), int'(e_done && !m_cons));
            chk("d1_clr",   int'(bus.dp2reg_d1_op_en_clr), int'(e_done && m_cons));
            chk("consumer", int'(bus.dp2reg_consumer),     int'(m_cons));
            chk("slcg",     int'(bus.slcg_op_en),          m_busy ? SLCG_ALL : 0);
            chk("int8",     int'(bus.cfg_is_int8),         int'(m_i8));
            chk("int16",    int'(bus.cfg_is_int16),        int'(m_i16));
            chk("fp16",     int'(bus.cfg_is_fp16),         int'(m_fp));
            chk("wg",       int'(bus.cfg_is_wg),           int'(m_wg));
            chk("prec_err", int'(bus.cfg_prec_err),        int'(m_err));
        end
        prdy_seen  = bus.dp_in_prdy;
        regen_seen = bus.cfg_reg_en;
        if (bus.cfg_reg_en)          ev_load = cyc;
        if (bus.dp2reg_done)         ev_done = cyc;
        if (bus.dp2reg_d0_op_en_clr) ev_clr0 = cyc;
        if (bus.dp2reg_d1_op_en_clr) ev_clr1 = cyc;
        if (bus.dp2reg_consumer != prev_cons) ev_cons = cyc;
        prev_cons = bus.dp2reg_consumer;
    endtask

    task automatic tick();
        @(negedge nvdla_core_clk);
        compare();
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 200 && dc < 0; i++) begin
            tick();
            if (bus.dp2reg_done) dc = cyc;
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_load(output int lc);
        lc = -1;
        for (int i = 0; i < 200 && lc < 0; i++) begin
            tick();
            if (bus.cfg_reg_en) lc = cyc;
        end
        if (lc < 0) chk("load_timeout", 0, 1);
    endtask

    task automatic set_grp(input bit g, input int prec, input bit wg, input int atoms);
        if (g) begin
            bus.reg2dp_d1_proc_precision = 2'(prec);
            bus.reg2dp_d1_conv_mode      = wg;
            bus.reg2dp_d1_atomics        = ATOMIC_W'(atoms);
        end else begin
            bus.reg2dp_d0_proc_precision = 2'(prec);
            bus.reg2dp_d0_conv_mode      = wg;
            bus.reg2dp_d0_atomics        = ATOMIC_W'(atoms);
        end
    endtask

    task automatic do_reset();
        nvdla_core_rst      = 1'b1;
        bus.reg2dp_d0_op_en = 1'b0;
        bus.reg2dp_d1_op_en = 1'b0;
        bus.dp_in_pvld      = 1'b0;
        set_grp(1'b0, 0, 1'b0, 0);
        set_grp(1'b1, 0, 1'b0, 0);
        tick();
        tick();
        nvdla_core_rst = 1'b0;
    endtask

    initial begin
        int t, dc, dc0, lc, npulse;
        logic [4:0] pat;

        do_reset();

        // d0 int8, 4 beats with pvld held high.
        set_grp(1'b0, 0, 1'b0, 3);
        bus.dp_in_pvld = 1'b1;
        bus.reg2dp_d0_op_en = 1'b1;
        t = cyc;
        wait_done(dc);
        bus.reg2dp_d0_op_en = 1'b0;
        chk("t1_load_cyc",   ev_load - t, 1);
        chk("t1_first_beat", bl_first - t, 2);
        chk("t1_beats",      bl_cnt, 4);
        chk("t1_last_beat",  bl_last - t, 5);
        chk("t1_done_cyc",   dc - t, 14);
        chk("t1_clr0_cyc",   ev_clr0 - t, 14);
        tick();
        chk("t1_consumer",   int'(bus.dp2reg_consumer), 1);
        chk("t1_cons_cyc",   ev_cons - t, 15);

        // Back-to-back d0 then d1.
        do_reset();
        set_grp(1'b0, 1, 1'b0, 0);
        set_grp(1'b1, 2, 1'b1, 1);
        bus.dp_in_pvld = 1'b1;
        bus.reg2dp_d0_op_en = 1'b1;
        bus.reg2dp_d1_op_en = 1'b1;
        wait_done(dc0);
        bus.reg2dp_d0_op_en = 1'b0;
        chk("t2_d0_clr", ev_clr0, dc0);
        wait_load(lc);
        chk("t2_d1_load_gap", lc - dc0, 2);
        tick();
        chk("t2_fp16",  int'(bus.cfg_is_fp16), 1);
        chk("t2_wg",    int'(bus.cfg_is_wg), 1);
        chk("t2_int16", int'(bus.cfg_is_int16), 0);
        wait_done(dc);
        bus.reg2dp_d1_op_en = 1'b0;
        chk("t2_d1_done_cyc", dc - lc, 11);
        chk("t2_d1_clr",      ev_clr1, dc);
        chk("t2_no_d0_clr",   ev_clr0, dc0);

        // pvld pattern 1,0,0,1,1 with three atomics.
        do_reset();
        set_grp(1'b0, 0, 1'b0, 2);
        bus.reg2dp_d0_op_en = 1'b1;
        t = cyc;
        tick();
        pat = 5'b11001;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.dp_in_pvld = pat[i];
        end
        tick();
        chk("t3_drain_prdy", int'(bus.dp_in_prdy), 0);
        bus.dp_in_pvld = 1'b1;
        wait_done(dc);
        bus.reg2dp_d0_op_en = 1'b0;
        chk("t3_beats",     bl_cnt, 3);
        chk("t3_last_beat", bl_last - t, 6);
        chk("t3_done_cyc",  dc - t, 15);

        // Illegal precision runs to completion; next legal load clears the error.
        do_reset();
        set_grp(1'b0, 3, 1'b0, 1);
        bus.dp_in_pvld = 1'b1;
        bus.reg2dp_d0_op_en = 1'b1;
        t = cyc;
        tick();
        tick();
        chk("t4_prec_err", int'(bus.cfg_prec_err), 1);
        chk("t4_flags",    int'({bus.cfg_is_int8, bus.cfg_is_int16, bus.cfg_is_fp16}), 0);
        wait_done(dc);
        bus.reg2dp_d0_op_en = 1'b0;
        chk("t4_done_cyc", dc - t, 12);
        set_grp(1'b1, 0, 1'b0, 0);
        bus.reg2dp_d1_op_en = 1'b1;
        wait_load(lc);
        tick();
        chk("t4_err_clr", int'(bus.cfg_prec_err), 0);
        chk("t4_int8",    int'(bus.cfg_is_int8), 1);
        wait_done(dc);
        bus.reg2dp_d1_op_en = 1'b0;

        // Software drops op_en and rewrites precision mid-RUN.
        do_reset();
        set_grp(1'b0, 2, 1'b0, 5);
        bus.dp_in_pvld = 1'b1;
        bus.reg2dp_d0_op_en = 1'b1;
        t = cyc;
        tick(); tick(); tick();
        bus.reg2dp_d0_op_en = 1'b0;
        set_grp(1'b0, 0, 1'b1, 0);
        tick();
        chk("t5_fp16_held", int'(bus.cfg_is_fp16), 1);
        chk("t5_wg_held",   int'(bus.cfg_is_wg), 0);
        wait_done(dc);
        chk("t5_done_cyc",  dc - t, 16);

        // Reset during DRAIN aborts without done.
        do_reset();
        set_grp(1'b0, 0, 1'b0, 0);
        bus.dp_in_pvld = 1'b1;
        bus.reg2dp_d0_op_en = 1'b1;
        t = cyc;
        while (cyc < t + 4) tick();
        nvdla_core_rst = 1'b1;
        tick();
        chk("t6_consumer", int'(bus.dp2reg_consumer), 0);
        chk("t6_int16",    int'(bus.cfg_is_int16), 1);
        chk("t6_prdy",     int'(bus.dp_in_prdy), 0);
        chk("t6_done",     int'(bus.dp2reg_done), 0);
        nvdla_core_rst = 1'b0;
        bus.reg2dp_d0_op_en = 1'b0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.dp2reg_done) npulse++;
        end
        chk("t6_no_done", npulse, 0);

        // Randomized traffic with mid-layer register churn and occasional reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (bus.dp2reg_d0_op_en_clr) bus.reg2dp_d0_op_en = 1'b0;
            if (bus.dp2reg_d1_op_en_clr) bus.reg2dp_d1_op_en = 1'b0;
            if ($urandom_range(7) == 0)
                set_grp(1'($urandom_range(1)), int'($urandom_range(3)),
                        1'($urandom_range(1)), int'($urandom_range(6)));
            if (!bus.reg2dp_d0_op_en && $urandom_range(5) == 0) bus.reg2dp_d0_op_en = 1'b1;
            if (!bus.reg2dp_d1_op_en && $urandom_range(5) == 0) bus.reg2dp_d1_op_en = 1'b1;
            bus.dp_in_pvld = ($urandom_range(3) != 0);
            nvdla_core_rst = ($urandom_range(299) == 0);
        end
        nvdla_core_rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cmac_op_sched.md
# nv_nvdla_cmac_op_sched

Operation scheduler for the CMAC core. It owns the ping-pong register-group consumer pointer and picks the enabled group. It latches that group's precision, mode and atomic count into shadow configuration for the MAC datapath, then gates atomic-op acceptance. It counts accepted atomics and drains the MAC pipeline before raising the per-layer done pulse and op-enable clear back to the register file. It sits between the CMAC register file (dual groups d0/d1) and the CMAC core configuration and datapath.

## Interface
- ATOMIC_W, 21: width of the programmed atomic count; the register holds count-1.
- DRAIN_CYC, 8: pipeline drain cycles after the last atomic; legal range 1..255.
- SLCG_W, 9: width of the clock-gate enable vector.

- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  reset, synchronous, active-high
- reg2dp_d0_op_en / reg2dp_d1_op_en  in  1  group op enable
- reg2dp_d0_proc_precision / reg2dp_d1_proc_precision  in  2  0=int8, 1=int16, 2=fp16, 3=illegal
- reg2dp_d0_conv_mode / reg2dp_d1_conv_mode  in  1  1=winograd
- reg2dp_d0_atomics / reg2dp_d1_atomics  in  ATOMIC_W  atomic count minus one
- dp_in_pvld  in  1  datapath offers one atomic op
- dp_in_prdy  out  1  scheduler accepts an atomic
- cfg_reg_en  out  1  one-cycle pulse: shadow config loaded
- cfg_is_int8, cfg_is_int16, cfg_is_fp16, cfg_is_wg  out  1 each  shadow config flags
- cfg_prec_err  out  1  latched precision was 3
- slcg_op_en  out  SLCG_W  clock-gate enable; all bits = (state != IDLE)
- dp2reg_consumer  out  1  group currently consumed
- dp2reg_done  out  1  one-cycle layer-done pulse
- dp2reg_d0_op_en_clr / dp2reg_d1_op_en_clr  out  1  one-cycle clear of the finished group's op_en

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE. All outputs are registered or decoded from state or registers only.
- IDLE: sel_op_en = consumer ? d1_op_en : d0_op_en. If sel_op_en=1, go to LOAD. The other group's op_en is ignored.
- LOAD (1 cycle):
  - Latch the selected group's precision, conv_mode and atomics into shadow registers.
  - cfg_reg_en=1.
  - Flag decode: cfg_is_int8=(prec==0), cfg_is_int16=(prec==1), cfg_is_fp16=(prec==2), cfg_is_wg=conv_mode, cfg_prec_err=(prec==3).
  - Clear the atomic counter.
  - Go to RUN.
- RUN:
  - dp_in_prdy=1; an atomic is accepted on pvld&prdy and increments the counter.
  - When the accepted atomic has counter==shadow_atomics, load drain_cnt=DRAIN_CYC-1 and go to DRAIN.
  - The counter never exceeds shadow_atomics and never wraps.
- DRAIN: dp_in_prdy=0. Decrement drain_cnt; go to DONE when drain_cnt==0.
- DONE (1 cycle):
  - dp2reg_done=1.
  - The clear for the current group fires: d0_clr when consumer=0, d1_clr when consumer=1.
  - Consumer toggles at the end of the cycle.
  - Go to IDLE.
- Shadow flags hold their value from LOAD until the next LOAD. Register-file changes during RUN or DRAIN have no effect.
- Software dropping op_en during RUN or DRAIN is ignored; the layer always completes.
- With precision 3 the layer runs normally with all three precision flags 0. cfg_prec_err stays set until the next LOAD.
- Reset values:
  - state=IDLE, consumer=0, counter=0, drain_cnt=0.
  - dp_in_prdy=0, cfg_reg_en=0, dp2reg_done=0, both op_en_clr outputs=0.
  - cfg_is_int8=0, cfg_is_int16=1, cfg_is_fp16=0, cfg_is_wg=0, cfg_prec_err=0, slcg_op_en=0.
- Reset asserted mid-layer aborts immediately to these values. No done or clr is issued for the aborted layer.

## Timing
- sel_op_en seen high in IDLE at cycle t:
  - cfg_reg_en high at t+1 (LOAD).
  - dp_in_prdy high from t+2.
  - Shadow flags valid from t+2.
- Last atomic accepted at cycle r:
  - DRAIN covers r+1..r+DRAIN_CYC.
  - dp2reg_done and clr high at r+DRAIN_CYC+1.
  - New consumer visible at r+DRAIN_CYC+2.
- There is at least one IDLE cycle between layers. If the next group's op_en is already high, its LOAD is at r+DRAIN_CYC+3.
- Minimum layer with atomics=0: one accepted beat, then DRAIN_CYC cycles, then DONE.
- dp_in_pvld low during RUN stalls the count with no timeout. pvld is ignored outside RUN.

## Test plan
- Group d0, int8, atomics=3, DRAIN_CYC=8, pvld held high:
  - cfg_reg_en pulse at t+1.
  - Exactly 4 beats accepted at t+2..t+5.
  - done and d0_clr at t+14.
  - consumer=1 at t+15.
- Back-to-back: d0 int16 atomics=0 and d1 fp16 wg atomics=1, both op_en set at start:
  - d0 runs first.
  - d1 LOAD begins 2 cycles after d0 done.
  - cfg_is_fp16=1 and cfg_is_wg=1 during d1.
  - d1_clr fires, not d0_clr.
- pvld toggled 1,0,0,1,1 with atomics=2: the count advances only on pvld&prdy, and DRAIN starts the cycle after the third accepted beat.
- Precision 3: cfg_prec_err=1 and all precision flags 0. The layer completes with done. The next legal LOAD clears cfg_prec_err.
- Software drops d0_op_en and rewrites d0 precision mid-RUN: shadow flags are unchanged and done still fires on schedule.
- Reset asserted during DRAIN: the next cycle shows state IDLE, consumer=0, cfg_is_int16=1, prdy=0, and no done pulse.
